demux1_2_reg: RTL
=================

// Module: demux1_2_reg
// PURPOSE
//   Registered 1-to-2 demultiplexer: the distribution counterpart of mux2_1.
//   Steers one 32-bit word stream to one of two consumers, chosen per word by sel.
//   Example: a datapath result routed to either register-file writeback (port 0)
//   or the store path (port 1).
//   Valid/ready handshake on all three sides.
//   Each output has a one-entry holding slot, so a stalled consumer never corrupts
//   the other port.
// PARAMETERS
//   WIDTH   32  data word width
//   CNT_W   16  width of the per-port completed-transfer counters
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   in_valid    in   1      input word valid
//   in_ready    out  1      block can accept the input word this cycle
//   in_data     in   WIDTH  input word
//   in_sel      in   1      destination: 0 -> port 0, 1 -> port 1
//   out0_valid  out  1      port-0 slot holds a word
//   out0_ready  in   1      port-0 consumer accepts
//   out0_data   out  WIDTH  port-0 word
//   out1_valid  out  1      port-1 slot holds a word
//   out1_ready  in   1      port-1 consumer accepts
//   out1_data   out  WIDTH  port-1 word
//   cnt0        out  CNT_W  completed port-0 transfers
//   cnt1        out  CNT_W  completed port-1 transfers
// BEHAVIOUR
//   Reset (rst_n low, asynchronous)
//   - outN_valid = 0, outN_data = 0, cntN = 0.
//   - in_ready follows its equation below.
//   - Any word held when reset is asserted is discarded; no partial transfer
//     survives reset.
//   Acceptance
//   - in_ready = ~outS_valid | outS_ready, where S = in_sel. Combinational; no
//     path from in_valid.
//   - in_sel and in_data are ignored whenever in_valid = 0.
//   - Accept = in_valid & in_ready. On accept, slot S loads in_data and outS_valid
//     is 1 from the next edge.
//   - Latency is exactly 1 cycle. With the destination free, 1 word per cycle to
//     either port (back-to-back, no bubbles).
//   Slot N, per edge
//   - Drain = outN_valid & outN_ready.
//   - Drain & no load: valid -> 0, data holds.
//   - Load & no drain (slot empty): valid -> 1, data <- in_data.
//   - Load & drain in the same cycle: valid stays 1, data <- in_data (pass-through,
//     no bubble).
//   - Neither: hold.
//   - The unselected slot is never written by an accept.
//   Output stability
//   - While outN_valid & ~outN_ready, outN_data and outN_valid do not change.
//   Ordering
//   - Order is preserved per port only. There is no ordering between ports.
//   - A blocked port never blocks words destined for the other port.
//   Counters
//   - cntN increments by 1 on each drain of port N.
//   - Wraps modulo 2^CNT_W (0xFFFF -> 0x0000 at default) with no flag.
//   Simultaneous events
//   - Both ports may drain in the same cycle.
//   - An accept may coincide with either or both drains; each slot follows the
//     slot rules above independently.
// STRUCTURE
//   - Shared package mips_pkg: WORD_W = 32; localparams SEL_P0 = 1'b0,
//     SEL_P1 = 1'b1; default CNT_W.
//   - Sub-module demux_slot: one-entry valid/data register with load, drain, ready
//     and counter. Instantiated twice; load_N = accept & (in_sel == N).
//   - The top level holds only the in_ready mux and the two instances.
// TESTING
//   1 Reset: rst_n = 0 with out ready high -> both valids 0, data 0, counts 0,
//     in_ready = 1.
//   2 Routing: send 650 (sel = 0), then 150 (sel = 1), ready high
//     -> out0_data = 650 and out1_data = 150, each one cycle after accept;
//     cnt0 = cnt1 = 1.
//   3 Backpressure: out0_ready = 0, send 10 then 20 to port 0
//     -> 10 accepted, 20 stalls (in_ready = 0). A sel = 1 word 30 is still
//     accepted. out0_data stays 10 until ready; then 10 and 20 drain in order.
//   4 Pass-through: port-0 slot full, out0_ready = 1, in_valid with sel = 0,
//     data 99 -> in_ready = 1, next cycle out0_data = 99, valid stays 1.
//   5 Wrap: preload cnt1 = 0xFFFF (CNT_W = 16) via transfers, one more drain
//     -> cnt1 = 0x0000.
//   6 Mid-operation reset: both slots full, pulse rst_n low asynchronously
//     between edges -> valids drop immediately; no stale word is seen after
//     release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths and demux port select codes
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W_DEF = 16;
  localparam logic SEL_P0 = 1'b0;
  localparam logic SEL_P1 = 1'b1;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry valid/data holding slot with drain counter
module demux_slot
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_free
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;
  assign w_drain = r_valid & i_ready;
  // The slot can take a word if it is empty or emptying this cycle, giving pass-through.
  assign o_free  = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  // Valid follows load/drain, data changes only on load, counter bumps on every drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= i_load | (r_valid & ~i_ready);
      r_data  <= i_load ? i_data : r_data;
      r_cnt   <= w_drain ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end
endmodule

// File: rtl/demux1_2_reg.sv
// demux1_2_reg: registered 1-to-2 demultiplexer with per-port holding slots
module demux1_2_reg
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic w_free0, w_free1, w_accept, w_load0, w_load1;
  // Readiness depends only on the selected slot, so a stalled port never blocks the other.
  assign in_ready = (in_sel == SEL_P1) ? w_free1 : w_free0;
  assign w_accept = in_valid & in_ready;
  assign w_load0  = w_accept & (in_sel == SEL_P0);
  assign w_load1  = w_accept & (in_sel == SEL_P1);
  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load0), .i_data(in_data), .i_ready(out0_ready),
    .o_valid(out0_valid), .o_data(out0_data), .o_cnt(cnt0), .o_free(w_free0)
  );
  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load1), .i_data(in_data), .i_ready(out1_ready),
    .o_valid(out1_valid), .o_data(out1_data), .o_cnt(cnt1), .o_free(w_free1)
  );
endmodule
